tqvp_vga_pmod_out: RTL and testbench
====================================

// Module: tqvp_vga_pmod_out
// PURPOSE
// - Output stage downstream of the sprite engine. Takes its per-pixel colour plus hsync/vsync/DE stream and drives the TinyVGA PMOD on uo_out.
// - Adds equal-latency pipelining, sync polarity, and frame-aligned enable and mode switching.
// - Provides a solid-colour mode and a colour-bar test mode, a frame counter, and a vsync interrupt.
// PARAMETERS
// - PIPE_DEPTH   2   cycles from pix_* input to uo_out; legal range >=1
// - FRAME_CNT_W  16  width of frame_cnt
// PORTS
// - clk            in   1   pixel/system clock
// - rst_n          in   1   reset, synchronous, active-low
// - pix_rgb        in   6   {R[1:0],G[1:0],B[1:0]} from sprite engine
// - pix_hsync      in   1   active-high hsync from engine timing
// - pix_vsync      in   1   active-high vsync from engine timing
// - pix_de         in   1   active-video flag
// - cfg_enable     in   1   request output on
// - cfg_mode       in   2   00 pixel, 01 solid, 10 colour bars, 11 treated as 00
// - cfg_solid_rgb  in   6   colour used in solid mode
// - cfg_hs_neg     in   1   1 = hsync driven active-low on pins
// - cfg_vs_neg     in   1   1 = vsync driven active-low on pins
// - irq_en         in   1   enable vsync interrupt
// - irq_clr        in   1   one-cycle pulse, clears irq
// - uo_out         out  8   {HS,B0,G0,R0,VS,B1,G1,R1}
// - frame_cnt      out  FRAME_CNT_W   frames completed while in RUN; wraps
// - irq            out  1   sticky vsync interrupt
// - state_o        out  2   00 IDLE, 01 ARM, 10 RUN, 11 DRAIN
// BEHAVIOUR
// - Reset: uo_out=8'h00, frame_cnt=0, irq=0, state IDLE, pipeline cleared, latched mode=00.
// - vs_rise: pix_vsync=1 while the previous-cycle registered copy of pix_vsync=0. Detected on the raw input, before the pipeline.
// - State machine:
//   - IDLE -> ARM when cfg_enable=1.
//   - ARM -> RUN on vs_rise; if cfg_enable drops while in ARM, ARM -> IDLE.
//   - RUN -> DRAIN when cfg_enable=0.
//   - DRAIN -> IDLE on vs_rise; DRAIN -> RUN if cfg_enable returns before that.
// - cfg_mode is sampled into the latched mode only on a vs_rise that enters RUN or occurs in RUN. Mid-frame mode changes never tear the frame.
// - In RUN/DRAIN: hs_o=pix_hsync, vs_o=pix_vsync, rgb_o chosen by latched mode.
//   - pixel: rgb_o = pix_rgb.
//   - solid: rgb_o = cfg_solid_rgb.
//   - bars: b = xcnt[9:7]; rgb_o = {{2{~b[2]}},{2{~b[1]}},{2{~b[0]}}}. Gives 8 bars of 128 px, bar0 white, bar7 black.
// - rgb_o is forced to 0 whenever pix_de=0, in every mode.
// - In IDLE/ARM: hs_o=0, vs_o=0, rgb_o=0, so pins sit at the inactive sync level.
// - xcnt (10 b): increments on each pix_de=1 cycle; cleared on any cycle with pix_de=0. Saturation is not needed at 1024 px.
// - Pipeline: {hs_o,vs_o,rgb_o} pass through PIPE_DEPTH register stages; all fields share identical latency.
// - Pin drive: HS pin = hs ^ cfg_hs_neg, VS pin = vs ^ cfg_vs_neg. Polarity is applied at the last stage, combinationally on the registered value, so a polarity change takes effect at once.
// - frame_cnt: +1 on each vs_rise while state is RUN or DRAIN (evaluated before the transition). Wraps all-ones -> 0.
// - irq: set on the same qualifying vs_rise when irq_en=1; cleared by irq_clr. Set and clear in the same cycle -> irq=1 (no lost event). irq_en=0 does not clear a pending irq.
// - Reset mid-frame: all state returns to reset values on the next clk edge; re-arming waits for a new vs_rise.
// STRUCTURE
// - Shared package/header: TinyVGA bit positions, MODE_* encodings, ST_IDLE/ST_ARM/ST_RUN/ST_DRAIN, bar colour function.
// - One sub-module: tqvp_vga_delay_line (param WIDTH, DEPTH; sync reset to 0), used for the 8-bit output pipeline.
// - FSM, xcnt, frame counter and irq live in the top module.
// TESTING
// - T1 reset: hold rst_n=0 for 3 clk -> uo_out=00, frame_cnt=0, irq=0, state_o=00.
// - T2 frame-aligned enable: cfg_enable=1 mid-frame, pix_rgb=6'b11_00_00, de=1.
//   - uo_out stays 00 until vs_rise, state_o=01.
//   - After vs_rise and PIPE_DEPTH cycles, a de pixel gives uo_out=8'h11.
// - T3 colour bars: mode=10 latched. de pixel 0 -> uo_out RGB bits all 1 (8'h77 with syncs low). Pixel 128 -> 8'h33 (yellow). Pixel 896 -> 8'h00.
// - T4 irq/counter: irq_en=1, two vs_rise in RUN -> frame_cnt=2, irq=1 one cycle after first rise. irq_clr coincident with the second rise -> irq remains 1.
// - T5 disable/mode mid-frame: cfg_enable=0 and cfg_mode=01 mid-frame.
//   - Pixel output unchanged until next vs_rise, with state_o=11.
//   - Then IDLE and uo_out=00.
//   - Re-enable -> solid colour after the following vs_rise.
// - T6 polarity/wrap: cfg_hs_neg=cfg_vs_neg=1 in IDLE -> uo_out=8'h88. With FRAME_CNT_W=4, 16 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/tqvp_vga_pmod_out_pkg.sv
// Shared definitions for the TinyVGA PMOD output stage: pin layout, mode
// encodings, FSM states and the colour-bar palette.
package tqvp_vga_pmod_out_pkg;

  // uo_out = {HS,B0,G0,R0,VS,B1,G1,R1}
  localparam logic [7:0] HS_BIT = 8'h80;
  localparam logic [7:0] VS_BIT = 8'h08;

  localparam logic [1:0] MODE_PIXEL = 2'b00;
  localparam logic [1:0] MODE_SOLID = 2'b01;
  localparam logic [1:0] MODE_BARS  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARM   = 2'b01,
    ST_RUN   = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  // 128-px bars: bar index 0 is white, 7 is black
  function automatic logic [5:0] bar_rgb(input logic [2:0] b);
    return {{2{~b[2]}}, {2{~b[1]}}, {2{~b[0]}}};
  endfunction

  // rgb is {R1,R0,G1,G0,B1,B0}
  function automatic logic [7:0] pack_pins(input logic hs, input logic vs,
                                           input logic [5:0] rgb);
    return {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
  endfunction

endpackage

// File: rtl/tqvp_vga_delay_line.sv
// Fixed-latency register chain; every bit of d sees exactly DEPTH clocks.
module tqvp_vga_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/tqvp_vga_pmod_out.sv
// TinyVGA PMOD output stage: frame-aligned enable/mode, test patterns,
// equal-latency output pipeline, frame counter and vsync interrupt.
module tqvp_vga_pmod_out
  import tqvp_vga_pmod_out_pkg::*;
#(
  parameter int PIPE_DEPTH  = 2,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             pix_rgb,
  input  logic                   pix_hsync,
  input  logic                   pix_vsync,
  input  logic                   pix_de,
  input  logic                   cfg_enable,
  input  logic [1:0]             cfg_mode,
  input  logic [5:0]             cfg_solid_rgb,
  input  logic                   cfg_hs_neg,
  input  logic                   cfg_vs_neg,
  input  logic                   irq_en,
  input  logic                   irq_clr,
  output logic [7:0]             uo_out,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   irq,
  output logic [1:0]             state_o
);

  state_t     state;
  logic       vs_q;
  logic [1:0] mode_q;
  logic [9:0] xcnt;
  logic       vs_rise;
  logic       active;
  logic [5:0] rgb_sel;
  logic [7:0] stage0;
  logic [7:0] pipe_q;

  assign vs_rise = pix_vsync & ~vs_q;
  assign active  = (state == ST_RUN) || (state == ST_DRAIN);

  always_comb begin
    rgb_sel = pix_rgb;
    case (mode_q)
      MODE_SOLID: rgb_sel = cfg_solid_rgb;
      MODE_BARS:  rgb_sel = bar_rgb(xcnt[9:7]);
      default:    rgb_sel = pix_rgb;
    endcase
  end

  assign stage0 = active ? pack_pins(pix_hsync, pix_vsync, pix_de ? rgb_sel : 6'd0)
                         : 8'h00;

  tqvp_vga_delay_line #(.WIDTH(8), .DEPTH(PIPE_DEPTH)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (stage0),
    .q     (pipe_q)
  );

  // Polarity sits after the pipeline so a change is visible immediately
  assign uo_out  = pipe_q ^ ({8{cfg_hs_neg}} & HS_BIT) ^ ({8{cfg_vs_neg}} & VS_BIT);
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vs_q      <= 1'b0;
      mode_q    <= MODE_PIXEL;
      xcnt      <= '0;
      frame_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      vs_q <= pix_vsync;
      xcnt <= pix_de ? xcnt + 10'd1 : 10'd0;

      if (vs_rise && active) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);

      // a new event wins over a coincident clear
      if (vs_rise && active && irq_en) irq <= 1'b1;
      else if (irq_clr)                irq <= 1'b0;

      if (vs_rise && ((state == ST_RUN) || (state == ST_ARM && cfg_enable)))
        mode_q <= cfg_mode;

      case (state)
        ST_IDLE:  if (cfg_enable) state <= ST_ARM;
        ST_ARM:   if (!cfg_enable) state <= ST_IDLE;
                  else if (vs_rise) state <= ST_RUN;
        ST_RUN:   if (!cfg_enable) state <= ST_DRAIN;
        ST_DRAIN: if (cfg_enable) state <= ST_RUN;
                  else if (vs_rise) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tqvp_vga_pmod_out.sv
// Scoreboard bench: the driver runs a frame-level reference model and queues
// expected pins/registers; a negedge monitor pops and compares them.
module tb_tqvp_vga_pmod_out;

  localparam int PD = 2;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    pix_rgb = '0;
  logic          pix_hsync = 1'b0, pix_vsync = 1'b0, pix_de = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [1:0]    cfg_mode = 2'b00;
  logic [5:0]    cfg_solid_rgb = 6'b00_11_01;
  logic          cfg_hs_neg = 1'b0, cfg_vs_neg = 1'b0;
  logic          irq_en = 1'b0, irq_clr = 1'b0;
  logic [7:0]    uo_out;
  logic [FW-1:0] frame_cnt;
  logic          irq;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  tqvp_vga_pmod_out #(.PIPE_DEPTH(PD), .FRAME_CNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_rgb(pix_rgb), .pix_hsync(pix_hsync),
    .pix_vsync(pix_vsync), .pix_de(pix_de), .cfg_enable(cfg_enable),
    .cfg_mode(cfg_mode), .cfg_solid_rgb(cfg_solid_rgb), .cfg_hs_neg(cfg_hs_neg),
    .cfg_vs_neg(cfg_vs_neg), .irq_en(irq_en), .irq_clr(irq_clr), .uo_out(uo_out),
    .frame_cnt(frame_cnt), .irq(irq), .state_o(state_o)
  );

  typedef struct { int due; logic [7:0] uo; } uo_e;
  typedef struct { int due; logic [1:0] st; logic [FW-1:0] fc; logic irq; } rg_e;
  uo_e uq[$];
  rg_e rq[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state: 0 idle, 1 arm, 2 run, 3 drain
  int m_st = 0, m_mode = 0, m_x = 0, m_fc = 0;
  bit m_vsp = 0, m_irq = 0;
  bit chaos = 0, rand_rgb = 1;
  logic [5:0] fixed_rgb = 6'b11_00_00;

  function automatic logic [7:0] pins(bit hs, bit vs, logic [5:0] c);
    logic [1:0] r, g, b;
    r = c[5:4]; g = c[3:2]; b = c[1:0];
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  task automatic push_uo(int due, logic [7:0] v);
    uo_e e; e.due = due; e.uo = v; uq.push_back(e);
  endtask

  task automatic push_rg();
    rg_e e; e.due = cyc; e.st = 2'(m_st); e.fc = FW'(m_fc); e.irq = m_irq;
    rq.push_back(e);
  endtask

  task automatic model_cycle();
    bit rise, act, set;
    int bar;
    logic [5:0] c;
    if (!rst_n) begin
      m_st = 0; m_mode = 0; m_x = 0; m_fc = 0; m_vsp = 0; m_irq = 0;
      uq.delete();
      for (int i = 0; i < PD; i++) push_uo(cyc + i, 8'h00);
      push_rg();
      return;
    end
    rise = pix_vsync && !m_vsp;
    act  = (m_st == 2) || (m_st == 3);
    bar  = m_x / 128;
    if (!pix_de)          c = 6'd0;
    else if (m_mode == 1) c = cfg_solid_rgb;
    else if (m_mode == 2) c = {(bar < 4) ? 2'b11 : 2'b00,
                               ((bar / 2) % 2 == 0) ? 2'b11 : 2'b00,
                               (bar % 2 == 0) ? 2'b11 : 2'b00};
    else                  c = pix_rgb;
    push_uo(cyc + PD - 1, act ? pins(pix_hsync, pix_vsync, c) : 8'h00);
    set = rise && act && irq_en;
    if (rise && act) m_fc = (m_fc + 1) % (1 << FW);
    if (set) m_irq = 1; else if (irq_clr) m_irq = 0;
    if (rise && (m_st == 2 || (m_st == 1 && cfg_enable)))
      m_mode = (cfg_mode == 2'b11) ? 0 : int'(cfg_mode);
    case (m_st)
      0: if (cfg_enable) m_st = 1;
      1: if (!cfg_enable) m_st = 0; else if (rise) m_st = 2;
      2: if (!cfg_enable) m_st = 3;
      default: if (cfg_enable) m_st = 2; else if (rise) m_st = 0;
    endcase
    m_x = pix_de ? (m_x + 1) % 1024 : 0;
    m_vsp = pix_vsync;
    push_rg();
  endtask

  always @(negedge clk) begin
    uo_e u;
    rg_e r;
    logic [7:0] exp;
    while (uq.size() > 0 && uq[0].due <= cyc) begin
      u = uq.pop_front();
      exp = u.uo ^ {cfg_hs_neg, 3'b000, cfg_vs_neg, 3'b000};
      checks++;
      if (u.due != cyc || uo_out !== exp) begin
        failures++;
        $display("FAIL uo_out cyc=%0d got=%h exp=%h", cyc, uo_out, exp);
      end
    end
    while (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      checks += 3;
      if (state_o !== r.st) begin
        failures++; $display("FAIL state_o cyc=%0d got=%0d exp=%0d", cyc, state_o, r.st);
      end
      if (frame_cnt !== r.fc) begin
        failures++; $display("FAIL frame_cnt cyc=%0d got=%0d exp=%0d", cyc, frame_cnt, r.fc);
      end
      if (irq !== r.irq) begin
        failures++; $display("FAIL irq cyc=%0d got=%0d exp=%0d", cyc, irq, r.irq);
      end
    end
  end

  task automatic step(bit h, bit v, bit de);
    pix_hsync = h; pix_vsync = v; pix_de = de;
    pix_rgb = rand_rgb ? 6'($urandom) : fixed_rgb;
    if (chaos) begin
      if ($urandom_range(0, 149) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 59) == 0)  cfg_mode = 2'($urandom);
      if ($urandom_range(0, 99) == 0)  cfg_solid_rgb = 6'($urandom);
      if ($urandom_range(0, 199) == 0) cfg_hs_neg = ~cfg_hs_neg;
      if ($urandom_range(0, 199) == 0) cfg_vs_neg = ~cfg_vs_neg;
      if ($urandom_range(0, 99) == 0)  irq_en = ~irq_en;
      irq_clr = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk);
    #1;
    model_cycle();
    irq_clr = 1'b0;
  endtask

  // hsync 4, back porch 2, active dl, front porch 2
  task automatic line(int dl, bit vs);
    for (int i = 0; i < 4; i++)  step(1'b1, vs, 1'b0);
    for (int i = 0; i < 2; i++)  step(1'b0, vs, 1'b0);
    for (int i = 0; i < dl; i++) step(1'b0, vs, !vs);
    for (int i = 0; i < 2; i++)  step(1'b0, vs, 1'b0);
  endtask

  task automatic frame(int nl, int dl, bit clr_on_rise);
    for (int i = 0; i < nl; i++) line(dl, 1'b0);
    if (clr_on_rise) irq_clr = 1'b1;
    line(dl, 1'b1);
    line(dl, 1'b1);
  endtask

  initial begin
    // reset held for three clocks
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // frame-aligned enable with a fixed red pixel
    rand_rgb = 1'b0;
    line(16, 1'b0);
    cfg_enable = 1'b1;
    line(16, 1'b0);
    frame(2, 16, 1'b0);
    frame(2, 16, 1'b0);
    rand_rgb = 1'b1;

    // colour bars across a full 1024-pixel line
    cfg_mode = 2'b10;
    frame(1, 1024, 1'b0);
    frame(1, 1024, 1'b0);

    // interrupt and frame counter, clear coincident with a rise
    irq_en = 1'b1;
    cfg_mode = 2'b00;
    frame(2, 20, 1'b0);
    frame(2, 20, 1'b1);
    irq_clr = 1'b1;
    line(20, 1'b0);

    // disable and mode change mid-frame, then re-enable
    cfg_enable = 1'b0;
    cfg_mode = 2'b01;
    line(20, 1'b0);
    frame(1, 20, 1'b0);
    frame(1, 20, 1'b0);
    cfg_enable = 1'b1;
    frame(2, 20, 1'b0);
    frame(2, 20, 1'b0);

    // inverted polarity while idle, then enough frames to wrap the counter
    cfg_enable = 1'b0;
    frame(1, 12, 1'b0);
    cfg_hs_neg = 1'b1; cfg_vs_neg = 1'b1;
    line(12, 1'b0);
    cfg_enable = 1'b1;
    cfg_mode = 2'b11;
    for (int f = 0; f < 18; f++) frame(2, 8, 1'b0);

    // randomised configuration churn with a reset landing mid-frame
    chaos = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if (f == 20) begin
        line(30, 1'b0);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
      end
      frame($urandom_range(1, 3), ($urandom_range(0, 5) == 0) ? 300 : 40, 1'b0);
    end
    chaos = 1'b0;

    repeat (PD + 2) @(negedge clk);
    checks++;
    if (uq.size() != 0 || rq.size() != 0) begin
      failures++;
      $display("FAIL drain pending uo=%0d reg=%0d exp=0", uq.size(), rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
